// File: rtl/tea_io_pkg.sv
// Shared constants for the tea_cpu byte-stream I/O peripheral.
// Register addresses and STATUS bit positions.
package tea_io_pkg;

    localparam logic [4:0] TEA_IO_ADDR_DATA   = 5'h00;
    localparam logic [4:0] TEA_IO_ADDR_STATUS = 5'h01;
    localparam logic [4:0] TEA_IO_ADDR_RXCNT  = 5'h02;
    localparam logic [4:0] TEA_IO_ADDR_TXCNT  = 5'h03;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_RX_UDF   = 4;
    localparam int ST_TX_OVF   = 5;

endpackage

// File: rtl/tea_io_sync_fifo.sv
// Synchronous byte FIFO, 2**FIFO_DEPTH_WIDTH entries.
// Head is presented combinationally and reads 0 when empty.
module tea_io_sync_fifo #(
    parameter int FIFO_DEPTH_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [7:0]                din,
    output logic [7:0]                dout,
    output logic                      empty,
    output logic                      full,
    output logic [FIFO_DEPTH_WIDTH:0] count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;

    logic [7:0]                  mem_q [DEPTH];
    logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_WIDTH:0]   count_q, count_d;
    logic                        do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_DEPTH_WIDTH+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + FIFO_DEPTH_WIDTH'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_DEPTH_WIDTH'(do_pop);
        count_d  = count_q + (FIFO_DEPTH_WIDTH+1)'(do_push)
                           - (FIFO_DEPTH_WIDTH+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tea_io_fifo.sv
// tea_cpu I/O-bus byte-stream peripheral with RX/TX FIFOs.
// Optional macro TEA_IO_COUNT_EN enables RX_COUNT/TX_COUNT reads.
module tea_io_fifo
    import tea_io_pkg::*;
#(
    parameter int FIFO_DEPTH_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data
);

    logic       rd_q, wr_q;
    logic       rx_udf_q, rx_udf_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic [7:0] rddata_q, rddata_d;

    logic       rd_acc, wr_acc, rd_data, wr_data, wr_stat;
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic       tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0] rx_head, status;
    logic [FIFO_DEPTH_WIDTH:0] rx_cnt, tx_cnt;

    assign rd_acc  = io_rd & ~rd_q;
    assign wr_acc  = io_wr & ~wr_q;
    assign rd_data = rd_acc & (io_addr == TEA_IO_ADDR_DATA);
    assign wr_data = wr_acc & (io_addr == TEA_IO_ADDR_DATA);
    assign wr_stat = wr_acc & (io_addr == TEA_IO_ADDR_STATUS);

    assign rx_push = s_valid & ~rx_full;
    assign rx_pop  = rd_data & ~rx_empty;
    assign tx_push = wr_data & ~tx_full;
    assign tx_pop  = m_ready & ~tx_empty;

    assign s_ready   = ~rx_full;
    assign m_valid   = ~tx_empty;
    assign io_rddata = rddata_q;

    tea_io_sync_fifo #(.FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
        .din(s_data), .dout(rx_head), .empty(rx_empty),
        .full(rx_full), .count(rx_cnt)
    );

    tea_io_sync_fifo #(.FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
        .din(io_wrdata), .dout(m_data), .empty(tx_empty),
        .full(tx_full), .count(tx_cnt)
    );

`ifndef TEA_IO_COUNT_EN
    logic unused_cnt;
    assign unused_cnt = ^{rx_cnt, tx_cnt};
`endif

    always_comb begin
        status              = 8'h00;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_UDF]   = rx_udf_q;
        status[ST_TX_OVF]   = tx_ovf_q;
    end

    // Clear first so a same-cycle set wins over W1C.
    always_comb begin
        rx_udf_d = rx_udf_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_stat && io_wrdata[ST_RX_UDF]) rx_udf_d = 1'b0;
        if (wr_stat && io_wrdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
        if (rd_data && rx_empty) rx_udf_d = 1'b1;
        if (wr_data && tx_full)  tx_ovf_d = 1'b1;
    end

    always_comb begin
        rddata_d = rddata_q;
        if (rd_acc) begin
            case (io_addr)
                TEA_IO_ADDR_DATA:   rddata_d = rx_head;
                TEA_IO_ADDR_STATUS: rddata_d = status;
`ifdef TEA_IO_COUNT_EN
                TEA_IO_ADDR_RXCNT:  rddata_d = 8'(rx_cnt);
                TEA_IO_ADDR_TXCNT:  rddata_d = 8'(tx_cnt);
`endif
                default:            rddata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rx_udf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rddata_q <= 8'h00;
        end else begin
            rd_q     <= io_rd;
            wr_q     <= io_wr;
            rx_udf_q <= rx_udf_d;
            tx_ovf_q <= tx_ovf_d;
            rddata_q <= rddata_d;
        end
    end

endmodule
